// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types for the writeback stage (op codes, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_OP_W = 4;

    typedef enum logic [WB_OP_W-1:0] {
        WB_NONE   = 4'd0,
        WB_MFHI   = 4'd1,
        WB_MFLO   = 4'd2,
        WB_MTHI   = 4'd3,
        WB_MTLO   = 4'd4,
        WB_MFC0   = 4'd5,
        WB_MTC0   = 4'd6,
        WB_ERET   = 4'd7,
        WB_MULDIV = 4'd8
    } wb_op_e;

    typedef enum logic [1:0] {
        WB_ST_EMPTY     = 2'd0,
        WB_ST_FULL      = 2'd1,
        WB_ST_WAIT_LOAD = 2'd2
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_regs.sv
`default_nettype none
// ============================================================================
// Module      : hilo_regs
// Description : HI/LO register pair with independent write enables and data.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_regs #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (we_hi) r_hi <= hi_wdata;
            if (we_lo) r_lo <= lo_wdata;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Pipelined MIPS writeback stage with valid/allow_in handshake,
//               HI/LO ownership, load wait and exception/ERET flush.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int EX_W    = 6,
    parameter int RADDR_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_in,
    output logic                allow_in,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [RADDR_W-1:0]  dest_in,
    input  logic [EX_W-1:0]     ex_in,
    input  logic                reg_we_in,
    input  logic                is_bd_in,
    input  logic                is_load_in,
    input  logic [WB_OP_W-1:0]  op_in,
    input  logic [7:0]          cp0_sel_in,
    input  logic [DATA_W-1:0]   wb_value_in,
    input  logic [DATA_W-1:0]   hi_in,
    input  logic [DATA_W-1:0]   lo_in,
    input  logic                mem_rdata_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                regfile_we,
    output logic [RADDR_W-1:0]  regfile_waddr,
    output logic [DATA_W-1:0]   regfile_wdata,
    output logic                cp0_we,
    output logic [7:0]          cp0_addr,
    output logic [DATA_W-1:0]   cp0_wdata,
    input  logic [DATA_W-1:0]   cp0_rdata,
    output logic                exc_commit,
    output logic [EX_W-1:0]     exc_vec,
    output logic [DATA_W-1:0]   exc_epc,
    output logic                exc_bd,
    output logic                eret,
    output logic                flush,
    output logic                fwd_valid,
    output logic [RADDR_W-1:0]  fwd_dest,
    output logic [DATA_W-1:0]   fwd_data
);

    localparam logic [1:0] c_ST_EMPTY     = WB_ST_EMPTY;
    localparam logic [1:0] c_ST_FULL      = WB_ST_FULL;
    localparam logic [1:0] c_ST_WAIT_LOAD = WB_ST_WAIT_LOAD;

    logic [1:0]          r_state;
    logic [DATA_W-1:0]   r_pc;
    logic [RADDR_W-1:0]  r_dest;
    logic [EX_W-1:0]     r_ex;
    logic                r_reg_we;
    logic                r_is_bd;
    logic                r_is_load;
    logic [WB_OP_W-1:0]  r_op;
    logic [7:0]          r_cp0_sel;
    logic [DATA_W-1:0]   r_wb_value;
    logic [DATA_W-1:0]   r_hi_in;
    logic [DATA_W-1:0]   r_lo_in;

    logic                w_commit;
    logic                w_exc;
    logic                w_ok;
    logic                w_flush;
    logic                w_allow;
    logic                w_accept;
    logic                w_we_hi;
    logic                w_we_lo;
    logic [DATA_W-1:0]   w_hi;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_result;

    assign w_exc    = |r_ex;
    // mem_rdata_valid only matters while a load is actually waiting
    assign w_commit = (r_state == c_ST_FULL) ||
                      ((r_state == c_ST_WAIT_LOAD) && mem_rdata_valid);
    assign w_ok     = w_commit && !w_exc;
    assign w_flush  = w_commit && (w_exc || (r_op == WB_ERET));
    assign w_allow  = (r_state == c_ST_EMPTY) || (w_commit && !w_flush);
    assign w_accept = valid_in && w_allow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_EMPTY;
            r_pc       <= '0;
            r_dest     <= '0;
            r_ex       <= '0;
            r_reg_we   <= 1'b0;
            r_is_bd    <= 1'b0;
            r_is_load  <= 1'b0;
            r_op       <= WB_NONE;
            r_cp0_sel  <= '0;
            r_wb_value <= '0;
            r_hi_in    <= '0;
            r_lo_in    <= '0;
        end else if (w_accept) begin
            r_state    <= (is_load_in && (ex_in == '0)) ? c_ST_WAIT_LOAD : c_ST_FULL;
            r_pc       <= pc_in;
            r_dest     <= dest_in;
            r_ex       <= ex_in;
            r_reg_we   <= reg_we_in;
            r_is_bd    <= is_bd_in;
            r_is_load  <= is_load_in;
            r_op       <= op_in;
            r_cp0_sel  <= cp0_sel_in;
            r_wb_value <= wb_value_in;
            r_hi_in    <= hi_in;
            r_lo_in    <= lo_in;
        end else if (w_commit) begin
            r_state    <= c_ST_EMPTY;
        end
    end

    // MULDIV writes both halves on the same edge from their own sources
    assign w_we_hi = w_ok && ((r_op == WB_MTHI) || (r_op == WB_MULDIV));
    assign w_we_lo = w_ok && ((r_op == WB_MTLO) || (r_op == WB_MULDIV));

    hilo_regs #(
        .DATA_W   (DATA_W)
    ) u_hilo (
        .clock    (clock),
        .reset    (reset),
        .we_hi    (w_we_hi),
        .we_lo    (w_we_lo),
        .hi_wdata ((r_op == WB_MULDIV) ? r_hi_in : r_wb_value),
        .lo_wdata ((r_op == WB_MULDIV) ? r_lo_in : r_wb_value),
        .hi       (w_hi),
        .lo       (w_lo)
    );

    always_comb begin
        w_result = r_wb_value;
        case (r_op)
            WB_MFHI: w_result = w_hi;
            WB_MFLO: w_result = w_lo;
            WB_MFC0: w_result = cp0_rdata;
            default: w_result = r_is_load ? mem_rdata : r_wb_value;
        endcase
    end

    assign allow_in      = w_allow;
    assign flush         = w_flush;

    assign regfile_we    = w_ok && r_reg_we;
    assign regfile_waddr = regfile_we ? r_dest : '0;
    assign regfile_wdata = regfile_we ? w_result : '0;

    assign cp0_we        = w_ok && (r_op == WB_MTC0);
    assign cp0_addr      = r_cp0_sel;
    assign cp0_wdata     = cp0_we ? r_wb_value : '0;

    assign eret          = w_ok && (r_op == WB_ERET);

    assign exc_commit    = w_commit && w_exc;
    assign exc_vec       = exc_commit ? r_ex : '0;
    assign exc_epc       = exc_commit ? (r_is_bd ? (r_pc - DATA_W'(4)) : r_pc) : '0;
    assign exc_bd        = exc_commit && r_is_bd;

    assign fwd_valid     = r_reg_we && !w_exc && ((r_state == c_ST_FULL) || w_commit);
    assign fwd_dest      = fwd_valid ? r_dest : '0;
    assign fwd_data      = fwd_valid ? w_result : '0;

endmodule
`default_nettype wire
